// File: rtl/lock_entry_controller_pkg.sv
// Shared definitions for the combination lock: state encodings and entry geometry.
package lock_entry_controller_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned COUNT_W    = 3;

  // Encodings are fixed because the display stage decodes them directly.
  typedef enum logic [1:0] {
    ST_INITIAL  = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_LOCKED   = 2'b10
  } state_e;

  // Slot 0 holds the first digit entered.
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] entry_buf_t;

endpackage

// File: rtl/lock_entry_controller_btn_edge_detect.sv
// Rising-edge detector for one debounced button level.
module lock_entry_controller_btn_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  // History register; resets high so a button held through reset produces no edge.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) btn_q <= 1'b1;
    else       btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/lock_entry_controller.sv
// Control FSM of the 4-digit hex combination lock: digit capture, code store/compare,
// retry counting and timed lockout.
module lock_entry_controller
  import lock_entry_controller_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter_button,
  input  logic               set_button,
  input  logic               change_button,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] hex1,
  output logic [DIGIT_W-1:0] hex2,
  output logic [DIGIT_W-1:0] hex3,
  output logic [DIGIT_W-1:0] hex4,
  output logic [1:0]         counter,
  output logic [COUNT_W-1:0] digit_count,
  output logic [1:0]         state,
  output logic               lockout,
  output logic               unlock_pulse,
  output logic               fail_pulse
);

  localparam int unsigned        TIMER_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]         TRIES_LIMIT = 4'(MAX_TRIES);
  localparam logic [COUNT_W-1:0] FULL_COUNT  = COUNT_W'(NUM_DIGITS);

  state_e             state_q, state_n;
  entry_buf_t         buf_q, code_q;
  logic [COUNT_W-1:0] count_q;
  logic [3:0]         fail_cnt_q;
  logic               lockout_q, unlock_q, fail_q;
  logic [TIMER_W-1:0] timer_q;

  logic enter_rise, set_rise, change_rise;
  logic set_ev, chg_ev, ent_ev, buf_full;
  logic capture, clear_buf, load_code, erase_code, hit, miss;

  lock_entry_controller_btn_edge_detect u_enter_edge (
    .clock (clock), .reset (reset), .btn (enter_button), .rise (enter_rise)
  );
  lock_entry_controller_btn_edge_detect u_set_edge (
    .clock (clock), .reset (reset), .btn (set_button), .rise (set_rise)
  );
  lock_entry_controller_btn_edge_detect u_change_edge (
    .clock (clock), .reset (reset), .btn (change_button), .rise (change_rise)
  );

  // Buttons are dead during lockout; set outranks change, change outranks enter.
  assign set_ev   = set_rise & ~lockout_q;
  assign chg_ev   = change_rise & ~lockout_q & ~set_rise;
  assign ent_ev   = enter_rise & ~lockout_q & ~set_rise & ~change_rise;
  assign buf_full = (count_q == FULL_COUNT);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_INITIAL;
    else       state_q <= state_n;
  end

  // Next-state and datapath action decode.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n    = state_q;
    capture    = 1'b0;
    clear_buf  = 1'b0;
    load_code  = 1'b0;
    erase_code = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    if (state_q != ST_INITIAL && state_q != ST_UNLOCKED && state_q != ST_LOCKED) begin
      state_n   = ST_INITIAL;
      clear_buf = 1'b1;
    end else if (set_ev) begin
      if (buf_full) begin
        clear_buf = 1'b1;
        case (state_q)
          ST_LOCKED: begin
            if (buf_q == code_q) begin
              hit     = 1'b1;
              state_n = ST_UNLOCKED;
            end else begin
              miss    = 1'b1;
            end
          end
          default: begin
            load_code = 1'b1;
            state_n   = ST_LOCKED;
          end
        endcase
      end else if (count_q == '0 && state_q == ST_UNLOCKED) begin
        state_n = ST_LOCKED;
      end
    end else if (chg_ev) begin
      if (count_q != '0) begin
        clear_buf = 1'b1;
      end else if (state_q == ST_UNLOCKED) begin
        erase_code = 1'b1;
        state_n    = ST_INITIAL;
      end
    end else if (ent_ev && !buf_full) begin
      capture = 1'b1;
    end
  end

  // Entry buffer, stored code, retry counter, lockout timer and result pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q      <= '0;
      count_q    <= '0;
      code_q     <= '0;
      fail_cnt_q <= '0;
      lockout_q  <= 1'b0;
      timer_q    <= '0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      unlock_q <= hit;
      fail_q   <= miss;

      if (clear_buf) begin
        buf_q   <= '0;
        count_q <= '0;
      end else if (capture) begin
        buf_q[count_q[1:0]] <= digit_in;
        count_q             <= count_q + COUNT_W'(1);
      end

      if (load_code)       code_q <= buf_q;
      else if (erase_code) code_q <= '0;

      if (lockout_q) begin
        if (timer_q == '0) begin
          lockout_q  <= 1'b0;
          fail_cnt_q <= '0;
        end else begin
          timer_q <= timer_q - TIMER_W'(1);
        end
      end else if (hit) begin
        fail_cnt_q <= '0;
      end else if (miss) begin
        if (fail_cnt_q != 4'hF) fail_cnt_q <= fail_cnt_q + 4'd1;
        if (fail_cnt_q >= TRIES_LIMIT - 4'd1) begin
          lockout_q <= 1'b1;
          timer_q   <= TIMER_LOAD;
        end
      end
    end
  end

  // Output drive straight from registered state.
  always_comb begin
    hex1         = buf_q[0];
    hex2         = buf_q[1];
    hex3         = buf_q[2];
    hex4         = buf_q[3];
    counter      = count_q[1:0];
    digit_count  = count_q;
    state        = state_q;
    lockout      = lockout_q;
    unlock_pulse = unlock_q;
    fail_pulse   = fail_q;
  end

endmodule

// File: tb/tb_lock_entry_controller.sv
// Scoreboard bench for lock_entry_controller: stimulus queues the expected output snapshot
// and the cycle it must appear; the monitor pops one entry each time the outputs change.
module tb_lock_entry_controller;

  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_U = 2'b01;
  localparam logic [1:0] S_L = 2'b10;
  localparam logic [2:0] B_ENT = 3'b001;
  localparam logic [2:0] B_SET = 3'b010;
  localparam logic [2:0] B_CHG = 3'b100;

  logic       clock, reset;
  logic       enter_button, set_button, change_button;
  logic [3:0] digit_in;
  logic [3:0] hex1, hex2, hex3, hex4;
  logic [1:0] counter;
  logic [2:0] digit_count;
  logic [1:0] state;
  logic       lockout, unlock_pulse, fail_pulse;

  lock_entry_controller #(
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enter_button  (enter_button),
    .set_button    (set_button),
    .change_button (change_button),
    .digit_in      (digit_in),
    .hex1          (hex1),
    .hex2          (hex2),
    .hex3          (hex3),
    .hex4          (hex4),
    .counter       (counter),
    .digit_count   (digit_count),
    .state         (state),
    .lockout       (lockout),
    .unlock_pulse  (unlock_pulse),
    .fail_pulse    (fail_pulse)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [25:0] snap;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] mk(input logic [1:0] st, input logic [2:0] cnt,
                                     input logic [15:0] hx, input logic lk, input logic up,
                                     input logic fp);
    return {st, cnt, cnt[1:0], hx, lk, up, fp};
  endfunction

  function automatic logic [25:0] sample();
    return {state, digit_count, counter, hex1, hex2, hex3, hex4, lockout, unlock_pulse, fail_pulse};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_snap(input string name, input int dly, input logic [1:0] st,
                             input logic [2:0] cnt, input logic [15:0] hx, input logic lk,
                             input logic up, input logic fp);
    exp_t e;
    e.name = name;
    e.cyc  = cyc + dly;
    e.snap = mk(st, cnt, hx, lk, up, fp);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic press(input logic [2:0] btns, input logic [3:0] d);
    digit_in      = d;
    enter_button  = btns[0];
    set_button    = btns[1];
    change_button = btns[2];
    @(posedge clock);
    #2;
    enter_button  = 1'b0;
    set_button    = 1'b0;
    change_button = 1'b0;
    @(posedge clock);
    #2;
  endtask

  task automatic enter_code(input logic [1:0] st, input logic [15:0] code);
    logic [15:0] hx;
    logic [3:0]  d;
    hx = '0;
    for (int i = 0; i < 4; i++) begin
      d  = code[15-4*i -: 4];
      hx = hx | (16'(d) << (12 - 4*i));
      expect_snap("digit_capture", 1, st, 3'(i + 1), hx, 1'b0, 1'b0, 1'b0);
      press(B_ENT, d);
    end
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    reset  = 1'b1;
    idle(n);
    reset  = 1'b0;
    check("reset_outputs", 32'(sample()), 32'(mk(S_I, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0)));
    mon_en = 1'b1;
  endtask

  // Monitor: any change of the observable outputs must match the oldest queued expectation.
  initial begin
    logic [25:0] prev, cur;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge clock);
      cur = sample();
      if (mon_en && cur !== prev) begin
        if (sb_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_change at cycle %0d: got %h expected no change from %h",
                   cyc, cur, prev);
        end else begin
          e = sb_q.pop_front();
          check(e.name, 32'(cur), 32'(e.snap));
          check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
      prev = cur;
    end
  end

  initial begin
    reset         = 1'b1;
    enter_button  = 1'b1;   // held through reset: must not register as an edge
    set_button    = 1'b0;
    change_button = 1'b0;
    digit_in      = 4'h0;
    do_reset(3);
    idle(2);
    enter_button = 1'b0;
    idle(1);

    // Program code 1234 from INITIAL.
    enter_code(S_I, 16'h1234);
    expect_snap("program_commit", 1, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);

    // Correct code unlocks with a one-cycle pulse.
    enter_code(S_L, 16'h1234);
    expect_snap("unlock_pulse_high", 1, S_U, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    expect_snap("unlock_pulse_low", 2, S_U, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);

    // Fifth digit is dropped; change clears a non-empty buffer.
    enter_code(S_U, 16'hABCD);
    press(B_ENT, 4'hE);
    expect_snap("change_clears", 1, S_U, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_CHG, 4'h0);

    // Set with three digits is ignored; buffer kept until change.
    expect_snap("partial_1", 1, S_U, 3'd1, 16'h5000, 1'b0, 1'b0, 1'b0);
    press(B_ENT, 4'h5);
    expect_snap("partial_2", 1, S_U, 3'd2, 16'h5600, 1'b0, 1'b0, 1'b0);
    press(B_ENT, 4'h6);
    expect_snap("partial_3", 1, S_U, 3'd3, 16'h5670, 1'b0, 1'b0, 1'b0);
    press(B_ENT, 4'h7);
    press(B_SET, 4'h0);
    expect_snap("partial_change", 1, S_U, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_CHG, 4'h0);

    // Simultaneous set+enter with a full buffer: new code 9876 committed, no capture.
    enter_code(S_U, 16'h9876);
    expect_snap("set_beats_enter", 1, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET | B_ENT, 4'hF);

    // New code unlocks, empty set relocks, unlock again, empty change erases.
    enter_code(S_L, 16'h9876);
    expect_snap("unlock2_high", 1, S_U, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    expect_snap("unlock2_low", 2, S_U, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    expect_snap("relock", 1, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    enter_code(S_L, 16'h9876);
    expect_snap("unlock3_high", 1, S_U, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    expect_snap("unlock3_low", 2, S_U, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    expect_snap("erase_code", 1, S_I, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_CHG, 4'h0);

    // Program 1111, then three wrong codes trigger a 20-cycle lockout.
    enter_code(S_I, 16'h1111);
    expect_snap("program2_commit", 1, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    for (int k = 0; k < 2; k++) begin
      enter_code(S_L, 16'h2222);
      expect_snap("fail_pulse_high", 1, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
      expect_snap("fail_pulse_low", 2, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
      press(B_SET, 4'h0);
    end
    enter_code(S_L, 16'h2222);
    expect_snap("lockout_start", 1, S_L, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    expect_snap("lockout_hold", 2, S_L, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    expect_snap("lockout_expire", 21, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    press(B_ENT, 4'h5);
    press(B_ENT, 4'h6);
    press(B_CHG, 4'h0);
    press(B_SET, 4'h0);
    idle(14);

    // Fail count was cleared at expiry: one wrong code only pulses fail.
    enter_code(S_L, 16'h3333);
    expect_snap("post_lockout_fail_high", 1, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_snap("post_lockout_fail_low", 2, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    enter_code(S_L, 16'h4444);
    expect_snap("fail2_high", 1, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    expect_snap("fail2_low", 2, S_L, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    enter_code(S_L, 16'h5555);
    expect_snap("lockout2_start", 1, S_L, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
    expect_snap("lockout2_hold", 2, S_L, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    press(B_SET, 4'h0);
    idle(3);

    // Reset mid-lockout returns everything to reset values; buttons work afterwards.
    do_reset(2);
    idle(25);
    expect_snap("after_reset_capture", 1, S_I, 3'd1, 16'h7000, 1'b0, 1'b0, 1'b0);
    press(B_ENT, 4'h7);
    idle(3);

    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
